// File: rtl/const_reg_checker.sv
// const_reg_checker: boot-time bus master that reads the three constant/ID
// words at 0x0, 0x4, 0x8 over an STB/WE/ACK handshake, captures them and
// compares each against its expected value. Reports pass, first mismatching
// index and ACK timeout. All outputs come from registers or from the state
// register alone; there is no combinational path from iACK/iDAT to outputs.
module const_reg_checker #(
  parameter logic [31:0] EXP_VER1 = 32'h0123_4567,
  parameter logic [31:0] EXP_VER2 = 32'h89AB_CDEF,
  parameter logic [31:0] EXP_VER3 = 32'hFEDC_BA98,
  parameter int unsigned TIMEOUT  = 16  // 2..255 cycles of STB without ACK
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  output logic [31:0] oADR,
  input  logic [31:0] iDAT,
  output logic        oSTB,
  output logic        oWE,
  input  logic        iACK,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oPASS,
  output logic        oTIMEOUT,
  output logic [1:0]  oERR_IDX,
  output logic [31:0] oID1,
  output logic [31:0] oID2,
  output logic [31:0] oID3
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [1:0] ERR_NONE = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  err_idx_q, err_idx_d;
  logic [31:0] id1_q, id1_d;
  logic [31:0] id2_q, id2_d;
  logic [31:0] id3_q, id3_d;

  // Expected word for a given read index.
  function automatic logic [31:0] exp_word(input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = EXP_VER1;
      2'd1:    w = EXP_VER2;
      2'd2:    w = EXP_VER3;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Next-state and result-update logic for the read sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    err_idx_d = err_idx_q;
    id1_d     = id1_q;
    id2_d     = id2_q;
    id3_d     = id3_q;
    case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          idx_d     = 2'd0;
          tmo_d     = 8'd0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          err_idx_d = ERR_NONE;
          id1_d     = 32'h0000_0000;
          id2_d     = 32'h0000_0000;
          id3_d     = 32'h0000_0000;
          state_d   = ST_REQ;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (iACK) begin
          case (idx_q)
            2'd0:    id1_d = iDAT;
            2'd1:    id2_d = iDAT;
            2'd2:    id3_d = iDAT;
            default: id1_d = id1_q;
          endcase
          // Case inequality so X/Z on the bus is a mismatch, not a silent pass.
          if ((iDAT !== exp_word(idx_q)) && (err_idx_q == ERR_NONE)) begin
            err_idx_d = idx_q;
          end else begin
            err_idx_d = err_idx_q;
          end
          if (idx_q == 2'd2) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_GAP;
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_FIN;
        end else begin
          tmo_d     = tmo_q + 8'd1;
        end
      end
      ST_GAP: begin
        tmo_d   = 8'd0;
        state_d = ST_REQ;
      end
      ST_FIN: begin
        pass_d  = (err_idx_q == ERR_NONE) && !timeout_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; synchronous reset wins over everything.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      tmo_q     <= 8'd0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_idx_q <= ERR_NONE;
      id1_q     <= 32'h0000_0000;
      id2_q     <= 32'h0000_0000;
      id3_q     <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_idx_q <= err_idx_d;
      id1_q     <= id1_d;
      id2_q     <= id2_d;
      id3_q     <= id3_d;
    end
  end

  // Bus and status outputs decoded from registered state only.
  always_comb begin
    oSTB     = (state_q == ST_REQ);
    oWE      = 1'b0;
    oADR     = {28'h000_0000, idx_q, 2'b00};
    oBUSY    = (state_q != ST_IDLE);
    oDONE    = (state_q == ST_FIN);
    oPASS    = pass_q;
    oTIMEOUT = timeout_q;
    oERR_IDX = err_idx_q;
    oID1     = id1_q;
    oID2     = id2_q;
    oID3     = id3_q;
  end

endmodule
